write_enable_seq: RTL and testbench

- Generates BRAM write strobes and addresses for periodic acquisitions locked to an external `end_cycle` pulse.
- Successor to the single-period write-enable generator, with four additions:
  - multi-period sequences of `n_periods` consecutive periods, for averaging;
  - a continuous mode;
  - a programmable start delay;
  - overrun detection.
- Sits between the DAC/ADC period timing and the accumulating BRAM write port of the averager.

---
 rtl/write_enable_seq.sv | 175 +++++++++++++++++
 tb/tb_write_enable_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_enable_seq.sv
// BRAM write-strobe/address sequencer locked to end_cycle pulses: arms for one
// partial period, then writes n_periods (or endless) bursts of count_max+1 words.
module write_enable_seq #(
    parameter int BRAM_WIDTH = 13,
    parameter int NPER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic                  end_cycle,
    input  logic [BRAM_WIDTH-1:0] count_max,
    input  logic [BRAM_WIDTH-1:0] delay,
    input  logic [NPER_WIDTH-1:0] n_periods,
    input  logic                  continuous,
    output logic                  wen,
    output logic [BRAM_WIDTH-1:0] count,
    output logic                  init,
    output logic                  first,
    output logic                  last,
    output logic [NPER_WIDTH-1:0] period_idx,
    output logic                  overrun,
    output logic                  ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DELAY,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BRAM_WIDTH-1:0] cnt_q, cnt_d;
    logic [BRAM_WIDTH-1:0] cmax_q, cmax_d;
    logic [BRAM_WIDTH-1:0] delay_q, delay_d;
    logic [NPER_WIDTH-1:0] nper_q, nper_d;
    logic                  cont_q, cont_d;
    logic                  wen_q, wen_d;
    logic [BRAM_WIDTH-1:0] count_q, count_d;
    logic                  init_q, init_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic [NPER_WIDTH-1:0] pidx_q, pidx_d;
    logic                  overrun_q, overrun_d;
    logic                  ready_q, ready_d;

    // One extra bit so period_idx+1 cannot wrap when compared to n_periods
    logic [NPER_WIDTH:0]   pidx_inc_ext;
    assign pidx_inc_ext = {1'b0, pidx_q} + {{NPER_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmax_d    = cmax_q;
        delay_d   = delay_q;
        nper_d    = nper_q;
        cont_d    = cont_q;
        count_d   = count_q;
        pidx_d    = pidx_q;
        overrun_d = overrun_q;
        wen_d     = 1'b0;

        if (restart) begin
            state_d   = S_ARM;
            cnt_d     = '0;
            cmax_d    = count_max;
            delay_d   = delay;
            nper_d    = (n_periods == '0) ? NPER_WIDTH'(1) : n_periods;
            cont_d    = continuous;
            pidx_d    = '0;
            overrun_d = 1'b0;
        end else begin
            if (end_cycle && (state_q == S_DELAY || state_q == S_WRITE)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                S_ARM: begin
                    if (cnt_q == cmax_q) begin
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + BRAM_WIDTH'(1);
                    end
                end
                S_WAIT: begin
                    if (end_cycle) begin
                        if (delay_q == '0) begin
                            state_d = S_WRITE;
                            count_d = '0;
                            wen_d   = 1'b1;
                        end else begin
                            state_d = S_DELAY;
                            cnt_d   = '0;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_q == delay_q - BRAM_WIDTH'(1)) begin
                        state_d = S_WRITE;
                        count_d = '0;
                        wen_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + BRAM_WIDTH'(1);
                    end
                end
                S_WRITE: begin
                    if (count_q == cmax_q) begin
                        if (cont_q || (pidx_inc_ext < {1'b0, nper_q})) begin
                            pidx_d  = pidx_inc_ext[NPER_WIDTH-1:0];
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        count_d = count_q + BRAM_WIDTH'(1);
                        wen_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Flags describe the write happening in the next cycle
        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
        init_d  = wen_d && (cmax_q != '0) && (count_d == cmax_q - BRAM_WIDTH'(1));
        first_d = wen_d && (pidx_d == '0);
        last_d  = wen_d && !cont_q && (pidx_d == nper_q - NPER_WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmax_q    <= '0;
            delay_q   <= '0;
            nper_q    <= '0;
            cont_q    <= 1'b0;
            wen_q     <= 1'b0;
            count_q   <= '0;
            init_q    <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            pidx_q    <= '0;
            overrun_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmax_q    <= cmax_d;
            delay_q   <= delay_d;
            nper_q    <= nper_d;
            cont_q    <= cont_d;
            wen_q     <= wen_d;
            count_q   <= count_d;
            init_q    <= init_d;
            first_q   <= first_d;
            last_q    <= last_d;
            pidx_q    <= pidx_d;
            overrun_q <= overrun_d;
            ready_q   <= ready_d;
        end
    end

    assign wen        = wen_q;
    assign count      = count_q;
    assign init       = init_q;
    assign first      = first_q;
    assign last       = last_q;
    assign period_idx = pidx_q;
    assign overrun    = overrun_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_write_enable_seq.sv
// Directed bench for write_enable_seq: each accepted end_cycle pushes its
// expected burst (cycle, address, flags) to a queue that a monitor drains.
module tb_write_enable_seq;

    localparam int BW = 13;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          end_cycle;
    logic [BW-1:0] count_max;
    logic [BW-1:0] delay;
    logic [NW-1:0] n_periods;
    logic          continuous;
    logic          wen;
    logic [BW-1:0] count;
    logic          init;
    logic          first;
    logic          last;
    logic [NW-1:0] period_idx;
    logic          overrun;
    logic          ready;

    write_enable_seq #(.BRAM_WIDTH(BW), .NPER_WIDTH(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .end_cycle  (end_cycle),
        .count_max  (count_max),
        .delay      (delay),
        .n_periods  (n_periods),
        .continuous (continuous),
        .wen        (wen),
        .count      (count),
        .init       (init),
        .first      (first),
        .last       (last),
        .period_idx (period_idx),
        .overrun    (overrun),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [BW-1:0] count;
        logic          init;
        logic          first;
        logic          last;
        logic [NW-1:0] pidx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    int            m_cmax;
    int            m_delay;
    int            m_nper_eff;
    bit            m_cont;
    logic [NW-1:0] m_pidx;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Writes scheduled for this cycle must appear with their flags; otherwise all strobes stay low
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                checkOutput("wr_wen",   32'(wen),        32'd1);
                checkOutput("wr_count", 32'(count),      32'(mon_e.count));
                checkOutput("wr_init",  32'(init),       32'(mon_e.init));
                checkOutput("wr_first", 32'(first),      32'(mon_e.first));
                checkOutput("wr_last",  32'(last),       32'(mon_e.last));
                checkOutput("wr_pidx",  32'(period_idx), 32'(mon_e.pidx));
            end else begin
                checkOutput("idle_strobes", {28'b0, wen, init, first, last}, 32'd0);
            end
        end
    end

    // Pulses end_cycle for one cycle; an accepted pulse schedules a whole burst
    task automatic applyStimulus(input bit accept);
        exp_t e;
        int   k;
        k = cyc;
        end_cycle = 1'b1;
        if (accept) begin
            for (int i = 0; i <= m_cmax; i++) begin
                e.cyc   = k + 1 + m_delay + i;
                e.count = BW'(i);
                e.init  = (m_cmax != 0) && (i == m_cmax - 1);
                e.first = (m_pidx == '0);
                e.last  = !m_cont && (int'(m_pidx) == m_nper_eff - 1);
                e.pidx  = m_pidx;
                sb.push_back(e);
            end
            m_pidx = m_pidx + NW'(1);
        end
        @(negedge clk);
        end_cycle = 1'b0;
    endtask

    task automatic applyRestart(input int cm, input int dl, input int np, input bit ct);
        count_max  = BW'(cm);
        delay      = BW'(dl);
        n_periods  = NW'(np);
        continuous = ct;
        restart    = 1'b1;
        m_cmax     = cm;
        m_delay    = dl;
        m_nper_eff = (np == 0) ? 1 : np;
        m_cont     = ct;
        m_pidx     = '0;
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
        checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        restart    = 1'b0;
        end_cycle  = 1'b0;
        count_max  = '0;
        delay      = '0;
        n_periods  = '0;
        continuous = 1'b0;
        m_cmax = 0; m_delay = 0; m_nper_eff = 1; m_cont = 0; m_pidx = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_wen",     32'(wen),        32'd0);
        checkOutput("rst_count",   32'(count),      32'd0);
        checkOutput("rst_flags",   {29'b0, init, first, last}, 32'd0);
        checkOutput("rst_pidx",    32'(period_idx), 32'd0);
        checkOutput("rst_overrun", 32'(overrun),    32'd0);
        checkOutput("rst_ready",   32'(ready),      32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single period, no delay; an end_cycle during ARM must be ignored
        applyRestart(7, 0, 1, 0);
        checkOutput("t1_arm_ready", 32'(ready), 32'd0);
        repeat (4) @(negedge clk);
        applyStimulus(0);
        repeat (3) @(negedge clk);
        applyStimulus(1);
        drain();
        checkOutput("t1_done_ready", 32'(ready), 32'd1);
        checkOutput("t1_done_count", 32'(count), 32'd7);
        checkOutput("t1_done_pidx",  32'(period_idx), 32'd0);

        // Three periods with a start delay of 3
        applyRestart(15, 3, 3, 0);
        repeat (16) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(1);
            repeat (39) @(negedge clk);
        end
        drain();
        checkOutput("t2_ready",   32'(ready),      32'd1);
        checkOutput("t2_overrun", 32'(overrun),    32'd0);
        checkOutput("t2_pidx",    32'(period_idx), 32'd2);
        checkOutput("t2_count",   32'(count),      32'd15);

        // Continuous mode: six periods, never ready, never last
        applyRestart(3, 0, 6, 1);
        repeat (4) @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            applyStimulus(1);
            repeat (9) @(negedge clk);
        end
        drain();
        checkOutput("t3_ready", 32'(ready),      32'd0);
        checkOutput("t3_pidx",  32'(period_idx), 32'd6);

        // end_cycle mid-burst raises overrun and is dropped
        applyRestart(31, 0, 2, 0);
        repeat (32) @(negedge clk);
        applyStimulus(1);
        repeat (19) @(negedge clk);
        applyStimulus(0);
        repeat (19) @(negedge clk);
        applyStimulus(1);
        drain();
        checkOutput("t4_overrun", 32'(overrun),    32'd1);
        checkOutput("t4_ready",   32'(ready),      32'd1);
        checkOutput("t4_pidx",    32'(period_idx), 32'd1);
        applyRestart(31, 0, 1, 0);
        checkOutput("t4_overrun_clr", 32'(overrun), 32'd0);

        // Restart at count 5, then input changes must not affect the new sequence
        applyRestart(15, 0, 1, 0);
        repeat (16) @(negedge clk);
        applyStimulus(1);
        repeat (5) @(negedge clk);
        applyRestart(15, 0, 1, 0);
        checkOutput("t5_wen_low", 32'(wen),   32'd0);
        checkOutput("t5_arm",     32'(ready), 32'd0);
        count_max = BW'(7);
        delay     = BW'(5);
        repeat (16) @(negedge clk);
        applyStimulus(1);
        drain();
        checkOutput("t5_count", 32'(count), 32'd15);
        checkOutput("t5_ready", 32'(ready), 32'd1);

        // Single-word period with n_periods of zero
        applyRestart(0, 0, 0, 0);
        repeat (1) @(negedge clk);
        applyStimulus(1);
        drain();
        checkOutput("t6_ready", 32'(ready), 32'd1);
        checkOutput("t6_count", 32'(count), 32'd0);

        // rst wins over a simultaneous restart
        rst       = 1'b1;
        restart   = 1'b1;
        count_max = BW'(5);
        @(negedge clk);
        sb.delete();
        checkOutput("t7_wen",     32'(wen),        32'd0);
        checkOutput("t7_count",   32'(count),      32'd0);
        checkOutput("t7_flags",   {29'b0, init, first, last}, 32'd0);
        checkOutput("t7_pidx",    32'(period_idx), 32'd0);
        checkOutput("t7_overrun", 32'(overrun),    32'd0);
        checkOutput("t7_ready",   32'(ready),      32'd1);
        rst     = 1'b0;
        restart = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
